// File: rtl/rot_share_arbiter.sv
// rot_share_arbiter: round-robin arbiter in front of one shared right-rotate
// datapath. One requester is granted per cycle. Its word is rotated and held
// in a single-entry output register that has its own valid/ready handshake.
module rot_share_arbiter #(
  parameter int N = 10,          // data width and rotation modulus
  parameter int R = 4,           // number of requesters (R >= 2)
  parameter int A = $clog2(N),   // amount width, derived from N
  parameter int I = $clog2(R)    // requester-id width, derived from R
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [R-1:0]     req_valid,
  input  logic [R*N-1:0]   req_data,
  input  logic [R*A-1:0]   req_amt,
  output logic [R-1:0]     req_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic [I-1:0]     out_id,
  input  logic             out_ready
);

  // Registered state
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q,  out_data_d;
  logic [I-1:0] out_id_q,    out_id_d;
  logic [I-1:0] ptr_q,       ptr_d;

  // Combinational intermediates
  logic         load;
  logic         grant_any;
  logic [I-1:0] gnt_id;
  logic [N-1:0] sel_data;
  logic [A-1:0] sel_amt;
  logic [A-1:0] amt_mod;
  logic [N-1:0] rot_data;

  // First valid requester at or after ptr, wrapping modulo R.
  function automatic logic [I-1:0] rr_pick(input logic [R-1:0] valid,
                                           input logic [I-1:0] ptr);
    logic         found;
    int           cand;
    logic [I-1:0] cand_idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < R; i++) begin
      cand = int'(ptr) + i;
      if (cand >= R) cand = cand - R;
      cand_idx = I'(cand);
      if (!found && valid[cand_idx]) begin
        found   = 1'b1;
        rr_pick = cand_idx;
      end
    end
  endfunction

  // The output slot can take a new result when empty or being drained now.
  assign load      = !out_valid_q || out_ready;
  assign grant_any = |req_valid;

  // Round-robin grant selection from the current pointer.
  always_comb begin
    gnt_id = rr_pick(req_valid, ptr_q);
  end

  // Route the granted requester's word and amount to the shared rotator.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel_data = '0;
    sel_amt  = '0;
    for (int r = 0; r < R; r++) begin
      if (gnt_id == I'(r)) begin
        sel_data = req_data[r*N +: N];
        sel_amt  = req_amt[r*A +: A];
      end
    end
  end

  // Reduce the amount modulo N. The amount field holds less than 2*N, so a
  // single conditional subtract is enough. When N is a power of two the
  // compare never fires.
  always_comb begin
    amt_mod = sel_amt;
    if (int'(sel_amt) >= N) amt_mod = sel_amt - A'(N);
  end

  // Right-rotate: shifting the doubled word gives out[k] = word[(k+amt) mod N].
  always_comb begin
    rot_data = N'({sel_data, sel_data} >> amt_mod);
  end

  // One-hot acceptance toward the granted requester. It is forced low in reset.
  always_comb begin
    req_ready = '0;
    if (!reset && load && grant_any) req_ready[gnt_id] = 1'b1;
  end

  // Next-state: capture on grant, empty the slot when idle, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_any) begin
        out_valid_d = 1'b1;
        out_data_d  = rot_data;
        out_id_d    = gnt_id;
        ptr_d       = (gnt_id == I'(R - 1)) ? '0 : gnt_id + I'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers. Asynchronous reset empties the slot and restarts the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples pre-edge values regardless of statement order.
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rot_share_arbiter.sv
// Scoreboard bench for rot_share_arbiter. A reference model predicts grants
// and rotated words and queues them. An independent monitor checks every
// consumed output against the queue.
module tb_rot_share_arbiter;

  localparam int N = 10;
  localparam int R = 4;
  localparam int A = $clog2(N);
  localparam int I = $clog2(R);

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_data;
  logic [R*A-1:0] req_amt;
  logic [R-1:0]   req_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [I-1:0]   out_id;
  logic           out_ready;

  rot_share_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    int           id;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Requester-side stimulus state
  logic [N-1:0] tb_data [R];
  logic [A-1:0] tb_amt  [R];
  logic [R-1:0] tb_valid;
  logic         tb_ready;

  // Reference model state
  int m_ptr;
  bit m_ov;
  int last_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // out[k] = w[(k + amt) mod N]
  function automatic logic [N-1:0] ref_rot(input logic [N-1:0] w, input int amt);
    logic [N-1:0] r;
    int idx;
    for (int k = 0; k < N; k++) begin
      idx  = (k + amt) % N;
      r[k] = w[idx];
    end
    return r;
  endfunction

  // First valid index searching p, p+1, ... mod R; -1 when none.
  function automatic int model_grant(input logic [R-1:0] v, input int p);
    int c;
    for (int i = 0; i < R; i++) begin
      c = (p + i) % R;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle. It is entered just after a rising edge. It applies the
  // inputs, checks the combinational handshake, predicts the transfer and
  // advances the model past the next edge.
  task automatic step();
    int         g;
    bit         ld;
    logic [R-1:0] exp_rdy;
    req_valid = tb_valid;
    out_ready = tb_ready;
    for (int r = 0; r < R; r++) begin
      req_data[r*N +: N] = tb_data[r];
      req_amt[r*A +: A]  = tb_amt[r];
    end
    #2;
    ld      = !m_ov || tb_ready;
    g       = model_grant(tb_valid, m_ptr);
    exp_rdy = '0;
    if (ld && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    last_grant = -1;
    if (ld && g >= 0) begin
      sb_q.push_back('{ref_rot(tb_data[g], int'(tb_amt[g])), g});
      m_ptr      = (g + 1) % R;
      m_ov       = 1'b1;
      last_grant = g;
    end else if (ld) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_flush();
    sb_q.delete();
    m_ptr = 0;
    m_ov  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_flush();
  endtask

  task automatic randomize_word(input int r);
    tb_data[r] = N'($urandom_range(0, (1 << N) - 1));
    tb_amt[r]  = A'($urandom_range(0, (1 << A) - 1));
  endtask

  task automatic drain();
    tb_valid = '0;
    tb_ready = 1'b1;
    step();
    step();
  endtask

  // Monitor: checks consumed results against the scoreboard, and checks
  // output stability while it is stalled.
  initial begin : monitor
    logic         hold;
    logic [N-1:0] hd;
    logic [I-1:0] hi;
    exp_t         e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold && out_valid) begin
          check("hold_data", 32'(out_data), 32'(hd));
          check("hold_id", 32'(out_id), 32'(hi));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: output data 0x%0h id %0d with no prediction queued", out_data, out_id);
          end else begin
            e = sb_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_id", 32'(out_id), 32'(e.id));
          end
        end
        hold = out_valid && !out_ready;
        hd   = out_data;
        hi   = out_id;
      end
    end
  end

  initial begin : stimulus
    int exp_rr[6];
    int exp_sp[3];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp_sp = '{3, 0, 3};

    // Reset state, with requests asserted to show that req_ready stays gated.
    reset     = 1'b1;
    req_valid = '1;
    req_data  = '0;
    req_amt   = '0;
    out_ready = 1'b0;
    tb_valid  = '0;
    tb_ready  = 1'b0;
    for (int r = 0; r < R; r++) begin
      tb_data[r] = '0;
      tb_amt[r]  = '0;
    end
    model_flush();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Rotation values from requester 0 only.
    tb_ready = 1'b1;
    tb_valid = 4'b0001;
    tb_data[0] = 10'h001; tb_amt[0] = 4'd1;  step();
    check("rot_amt1", 32'(out_data), 32'h200);
    check("rot_amt1_id", 32'(out_id), 32'd0);
    tb_data[0] = 10'h2A5; tb_amt[0] = 4'd0;  step();
    check("rot_amt0", 32'(out_data), 32'h2A5);
    tb_data[0] = 10'h021; tb_amt[0] = 4'd15; step();
    check("rot_amt15", 32'(out_data), 32'h021);
    tb_data[0] = 10'h2A5; tb_amt[0] = 4'd9;  step();
    check("rot_amt9", 32'(out_data), 32'h14B);
    tb_data[0] = 10'h0F3; tb_amt[0] = 4'd13; step();
    drain();

    // Round robin from reset with all requesters active.
    do_reset();
    tb_valid = 4'hF;
    for (int r = 0; r < R; r++) randomize_word(r);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_id", 32'(out_id), 32'(exp_rr[i]));
      if (last_grant >= 0) randomize_word(last_grant);
    end
    drain();

    // Sparse requests: ptr moved to 1, then only requesters 0 and 3 are active.
    do_reset();
    tb_valid = 4'b0001;
    randomize_word(0);
    step();
    tb_valid = 4'b1001;
    randomize_word(0);
    randomize_word(3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sparse_id", 32'(out_id), 32'(exp_sp[i]));
      if (last_grant >= 0) randomize_word(last_grant);
    end
    drain();

    // Backpressure: a held result, stalled requests, then a same-cycle swap.
    tb_valid = 4'hF;
    for (int r = 0; r < R; r++) randomize_word(r);
    step();
    randomize_word(last_grant);
    tb_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tb_ready = 1'b1;
    step();
    drain();

    // Idle drain: one result, then no requests; the pointer must survive.
    tb_valid = '0;
    tb_valid[1] = 1'b1;
    randomize_word(1);
    step();
    tb_valid = '0;
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    tb_valid = 4'hF;
    for (int r = 0; r < R; r++) randomize_word(r);
    step();
    check("idle_ptr_kept", 32'(out_id), 32'd2);
    drain();

    // Reset asserted between edges while a result is stalled.
    tb_valid = 4'hF;
    tb_ready = 1'b1;
    step();
    tb_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_flush();
    tb_valid = 4'b1010;
    tb_ready = 1'b1;
    for (int r = 0; r < R; r++) randomize_word(r);
    step();
    check("midrst_first_id", 32'(out_id), 32'd1);
    drain();

    // Randomized traffic. Pending requesters keep their word until granted.
    tb_valid = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int r = 0; r < R; r++) begin
        if (!tb_valid[r]) begin
          tb_valid[r] = ($urandom_range(0, 2) != 0);
          randomize_word(r);
        end
      end
      tb_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_grant >= 0) tb_valid[last_grant] = 1'b0;
    end
    drain();
    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rot_share_arbiter.md
# rot_share_arbiter

Round-robin arbiter that shares one N-bit right-rotate datapath between R requesters. Each requester presents a word and a rotate amount with a valid/ready handshake. The block grants one requester per cycle, rotates its word, and holds the result in a single-entry output register with its own valid/ready handshake. It sits between the lane clients and any downstream consumer of rotated words, so only one rotator instance exists per lane group.

## Interface
- N, 10, data width in bits and rotation modulus.
- R, 4, number of requesters (R >= 2).
- A, $clog2(N), amount width (derived; not overridden).
- I, $clog2(R), requester-id width (derived; not overridden).

- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  R  per-requester request valid.
- req_data  in  R*N  requester r word at [r*N +: N].
- req_amt  in  R*A  requester r amount at [r*A +: A].
- req_ready  out  R  one-hot (or zero) acceptance, combinational.
- out_valid  out  1  output register holds a result.
- out_data  out  N  rotated word.
- out_id  out  I  index of the requester that produced out_data.
- out_ready  in  1  downstream accepts out_data this cycle.

## Operation
- Rotation: out_data[k] = word[(k + amt) mod N] for k in 0..N-1. amt values >= N (possible when N is not a power of 2) rotate by amt mod N. amt = 0 passes the word through.
- load = !out_valid || out_ready. A new result may be captured only when load = 1.
- Arbitration: the grant is the first r with req_valid[r] = 1, searching ptr, ptr+1, ..., ptr+R-1 (mod R). grant_any = |req_valid.
- req_ready[g] = load && grant_any for the granted g; all other bits are 0. It is combinational from req_valid, ptr, out_valid and out_ready. There is no dependency from req_ready back to req_valid.
- On a clock edge with load && grant_any:
  - out_data <= rotate(req_data[g], req_amt[g]).
  - out_id <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod R.
- On a clock edge with load && !grant_any: out_valid <= 0. out_data, out_id and ptr are held.
- When load = 0 (out_valid && !out_ready), all state is held and req_ready = 0.
- Requesters must hold req_data and req_amt stable while req_valid=1 and req_ready=0. The block does not capture them until their grant.
- Simultaneous out_ready and new grant in the same cycle: the old result is consumed and the new one loaded in that cycle. Sustained throughput is 1 result per cycle.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - out_valid = 0, out_data = 0, out_id = 0, ptr = 0.
  - req_ready = 0 while reset = 1.
- Reset mid-transfer: out_valid drops immediately, without waiting for a clock edge. A pending result is discarded and ptr returns to 0. Requesters must re-present.
- Latency: a request accepted at edge t appears on out_valid/out_data/out_id immediately after edge t (1 cycle).
- Fairness: a requester that keeps req_valid high is granted within R accepted transfers.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_id must not change.

## Test plan
- Rotation values, N=10, R=4, requester 0 only, out_ready=1:
  - data=10'b0000000001, amt=1 -> out_data=10'b1000000000, out_id=0.
  - amt=0 -> word unchanged.
  - amt=15 -> same result as amt=5: 10'b0000100001 -> 10'b0000100001 rotated by 5 = 10'b0000100001.
  - data=10'h2A5, amt=9 -> 10'h14B.
- Round robin: all four req_valid held high from reset, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive edges. req_ready is one-hot every cycle, and out_valid stays 1 continuously.
- Sparse requests with pointer skip: ptr=1, only req_valid[0] and [3] high -> grant 3 first, then 0, then 3.
- Backpressure: out_ready=0 for 5 cycles with requests pending:
  - req_ready = 0 throughout.
  - out_data and out_id are stable.
  - on the first edge with out_ready=1, the next requester is loaded in the same cycle.
- Idle drain: single request, then req_valid=0 with out_ready=1 -> out_valid high for exactly 1 cycle. ptr is unchanged after out_valid drops.
- Reset mid-operation: assert reset between edges while out_valid=1 and out_ready=0:
  - out_valid=0 and req_ready=0 immediately.
  - after release, the first grant goes to the lowest valid index at or after 0.
